// File: rtl/distance_avg_pkg.sv
// Shared constants for the ultrasonic sensor path: window defaults, clamp ceiling,
// stale timeout and the averaging FSM state encoding.
package distance_avg_pkg;

    localparam int unsigned DEFAULT_DEPTH        = 8;
    localparam int unsigned DEFAULT_MAX_RANGE    = 200;
    localparam int unsigned DEFAULT_STALE_CYCLES = 50000000;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } avg_state_e;

    function automatic logic [7:0] clamp_sample(input logic [7:0] raw, input logic [7:0] ceiling);
        return (raw > ceiling) ? ceiling : raw;
    endfunction

endpackage

// File: rtl/distance_avg_sample_ring.sv
// DEPTH x 8 sample store; the entry at wr_ptr is both the oldest sample (read)
// and the slot the next sample overwrites.
module sample_ring
    import distance_avg_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[wr_ptr];

endmodule

// File: rtl/distance_avg.sv
// Moving-average filter for distance samples: clamps, windows over DEPTH samples
// and flags a stalled sensor.
//
// state      | meaning
// ST_EMPTY   | no samples held, avg_out tracks the raw clamped sample
// ST_FILLING | 1..DEPTH-1 samples held, avg_out tracks the latest clamped sample
// ST_FULL    | window full, avg_out is the window sum / DEPTH
module distance_avg
    import distance_avg_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned MAX_RANGE    = DEFAULT_MAX_RANGE,
    parameter int unsigned STALE_CYCLES = DEFAULT_STALE_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clear,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic [4:0] fill_count,
    output logic       full,
    output logic       stale
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = PTR_W + 8;
    localparam int unsigned CNT_W = $clog2(STALE_CYCLES + 1);

    avg_state_e       state_q, state_d;
    logic [4:0]       fill_q, fill_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [7:0]       avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
    logic [7:0]       oldest;
    logic [7:0]       s_clamped;

    assign s_clamped = clamp_sample(sample_in, 8'(MAX_RANGE));

    sample_ring #(.DEPTH(DEPTH)) u_ring (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (clear),
        .wr_en   (sample_valid),
        .wr_ptr  (wr_ptr_q),
        .wr_data (s_clamped),
        .rd_data (oldest)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_EMPTY;
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    // clear has priority: a coincident sample is dropped and avg_out is left alone
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (clear) begin
            state_d  = ST_EMPTY;
            fill_d   = '0;
            wr_ptr_d = '0;
            sum_d    = '0;
        end else if (sample_valid) begin
            sum_d       = sum_q - SUM_W'(oldest) + SUM_W'(s_clamped);
            wr_ptr_d    = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            avg_valid_d = 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_FILLING;
                    fill_d  = 5'd1;
                end
                ST_FILLING: begin
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'(DEPTH - 1)) state_d = ST_FULL;
                end
                ST_FULL: ;
                default: begin
                    state_d = ST_EMPTY;
                    fill_d  = '0;
                end
            endcase
            avg_d = (state_d == ST_FULL) ? 8'(sum_d >> PTR_W) : s_clamped;
        end
    end

    // saturating idle counter; clear does not touch it
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (sample_valid) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q != CNT_W'(STALE_CYCLES)) begin
            stale_cnt_d = stale_cnt_q + CNT_W'(1);
        end
    end

    assign avg_out    = avg_q;
    assign avg_valid  = avg_valid_q;
    assign fill_count = fill_q;
    assign full       = (fill_q == 5'(DEPTH));
    assign stale      = (stale_cnt_q == CNT_W'(STALE_CYCLES));

endmodule

// File: tb/tb_distance_avg.sv
// Self-checking bench for distance_avg against a queue-based moving-average model.
module tb_distance_avg;

    localparam int DEPTH = 8;
    localparam int MAXR  = 200;
    localparam int STALE = 100;

    logic       clock;
    logic       resetn;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clear;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic [4:0] fill_count;
    logic       full;
    logic       stale;

    int n_pass  = 0;
    int n_total = 0;
    int mq[$];
    int exp_avg = 0;

    distance_avg #(.DEPTH(DEPTH), .MAX_RANGE(MAXR), .STALE_CYCLES(STALE)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .fill_count   (fill_count),
        .full         (full),
        .stale        (stale)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: keep the last DEPTH clamped samples; average only once the window is full.
    function automatic int model_push(input int raw);
        int s;
        int total;
        s = (raw > MAXR) ? MAXR : raw;
        mq.push_back(s);
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (mq.size() == DEPTH) begin
            total = 0;
            foreach (mq[i]) total += mq[i];
            exp_avg = total / DEPTH;
        end else begin
            exp_avg = s;
        end
        return exp_avg;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] d, input logic c);
        sample_valid = v;
        sample_in    = d;
        clear        = c;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic do_clear();
        cycle(1'b0, 8'd0, 1'b1);
        mq.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        n_total++; if (avg_out !== 8'd0) $display("FAIL reset_avg: got %0d expected 0", avg_out); else n_pass++;
        n_total++; if (avg_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", avg_valid); else n_pass++;
        n_total++; if (fill_count !== 5'd0) $display("FAIL reset_fill: got %0d expected 0", fill_count); else n_pass++;
        n_total++; if ({full, stale} !== 2'b00) $display("FAIL reset_flags: got full=%0b stale=%0b expected 0 0", full, stale); else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        mq.delete();
        exp_avg = 0;
    endtask

    task automatic test_fill();
        int vals[3] = '{10, 20, 30};
        foreach (vals[i]) begin
            void'(model_push(vals[i]));
            cycle(1'b1, 8'(vals[i]), 1'b0);
            n_total++; if (avg_valid !== 1'b1) $display("FAIL fill_valid: got %0b expected 1", avg_valid); else n_pass++;
            n_total++; if (avg_out !== 8'(vals[i])) $display("FAIL fill_avg: got %0d expected %0d", avg_out, vals[i]); else n_pass++;
        end
        cycle(1'b0, 8'd0, 1'b0);
        n_total++; if (avg_valid !== 1'b0) $display("FAIL fill_pulse: got %0b expected 0", avg_valid); else n_pass++;
        n_total++; if (avg_out !== 8'd30) $display("FAIL fill_hold: got %0d expected 30", avg_out); else n_pass++;
        n_total++; if (fill_count !== 5'd3 || full !== 1'b0) $display("FAIL fill_count: got %0d/%0b expected 3/0", fill_count, full); else n_pass++;
    endtask

    task automatic test_full_avg();
        do_clear();
        n_total++; if (fill_count !== 5'd0 || avg_valid !== 1'b0) $display("FAIL clear_state: got fill=%0d valid=%0b expected 0 0", fill_count, avg_valid); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            void'(model_push(40));
            cycle(1'b1, 8'd40, 1'b0);
        end
        n_total++; if (avg_out !== 8'd40 || full !== 1'b1) $display("FAIL full_40: got avg=%0d full=%0b expected 40 1", avg_out, full); else n_pass++;
        void'(model_push(120));
        cycle(1'b1, 8'd120, 1'b0);
        n_total++; if (avg_out !== 8'd50) $display("FAIL full_wrap: got %0d expected 50", avg_out); else n_pass++;
        n_total++; if (fill_count !== 5'd8) $display("FAIL full_count: got %0d expected 8", fill_count); else n_pass++;
    endtask

    task automatic test_clamp();
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            void'(model_push(255));
            cycle(1'b1, 8'd255, 1'b0);
            n_total++; if (avg_out !== 8'd200) $display("FAIL clamp_avg: got %0d expected 200", avg_out); else n_pass++;
        end
        n_total++; if (full !== 1'b1) $display("FAIL clamp_full: got %0b expected 1", full); else n_pass++;
    endtask

    task automatic test_clear_collision();
        int held;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            void'(model_push(17 + i));
            cycle(1'b1, 8'(17 + i), 1'b0);
        end
        held = exp_avg;
        cycle(1'b1, 8'd99, 1'b1);
        mq.delete();
        n_total++; if (avg_valid !== 1'b0) $display("FAIL coll_valid: got %0b expected 0", avg_valid); else n_pass++;
        n_total++; if (avg_out !== 8'(held)) $display("FAIL coll_hold: got %0d expected %0d", avg_out, held); else n_pass++;
        n_total++; if (fill_count !== 5'd0 || full !== 1'b0) $display("FAIL coll_fill: got %0d/%0b expected 0/0", fill_count, full); else n_pass++;
        void'(model_push(33));
        cycle(1'b1, 8'd33, 1'b0);
        n_total++; if (avg_out !== 8'd33 || fill_count !== 5'd1) $display("FAIL coll_after: got avg=%0d fill=%0d expected 33 1", avg_out, fill_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic v;
        logic c;
        logic [7:0] d;
        int exp_valid;
        do_clear();
        for (int i = 0; i < 120; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            d = 8'($urandom_range(0, 255));
            exp_valid = 0;
            if (c) begin
                mq.delete();
            end else if (v) begin
                void'(model_push(int'(d)));
                exp_valid = 1;
            end
            cycle(v, d, c);
            n_total++;
            if (avg_valid !== 1'(exp_valid) || avg_out !== 8'(exp_avg) || fill_count !== 5'(mq.size())
                || full !== (mq.size() == DEPTH))
                $display("FAIL rand_step%0d: got v=%0b avg=%0d fill=%0d full=%0b expected v=%0d avg=%0d fill=%0d full=%0b",
                         i, avg_valid, avg_out, fill_count, full, exp_valid, exp_avg, mq.size(), mq.size() == DEPTH);
            else n_pass++;
        end
    endtask

    task automatic test_stale();
        void'(model_push(50));
        cycle(1'b1, 8'd50, 1'b0);
        n_total++; if (stale !== 1'b0) $display("FAIL stale_start: got %0b expected 0", stale); else n_pass++;
        repeat (STALE - 1) cycle(1'b0, 8'd0, 1'b0);
        n_total++; if (stale !== 1'b0) $display("FAIL stale_early: got %0b expected 0", stale); else n_pass++;
        cycle(1'b0, 8'd0, 1'b0);
        n_total++; if (stale !== 1'b1) $display("FAIL stale_rise: got %0b expected 1", stale); else n_pass++;
        repeat (30) cycle(1'b0, 8'd0, 1'b0);
        n_total++; if (stale !== 1'b1) $display("FAIL stale_sat: got %0b expected 1", stale); else n_pass++;
        do_clear();
        n_total++; if (stale !== 1'b1) $display("FAIL stale_clear: got %0b expected 1", stale); else n_pass++;
        void'(model_push(60));
        cycle(1'b1, 8'd60, 1'b0);
        n_total++; if (stale !== 1'b0) $display("FAIL stale_fall: got %0b expected 0", stale); else n_pass++;
    endtask

    task automatic test_reset_mid_full();
        do_clear();
        for (int i = 0; i < DEPTH + 2; i++) begin
            void'(model_push(int'($urandom_range(0, 255))));
            cycle(1'b1, 8'(mq[mq.size() - 1]), 1'b0);
        end
        n_total++; if (full !== 1'b1 || avg_out !== 8'(exp_avg)) $display("FAIL pre_reset: got full=%0b avg=%0d expected 1 %0d", full, avg_out, exp_avg); else n_pass++;
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        n_total++; if ({avg_out, avg_valid, fill_count, full, stale} !== 16'd0)
            $display("FAIL async_reset: got avg=%0d v=%0b fill=%0d full=%0b stale=%0b expected all 0",
                     avg_out, avg_valid, fill_count, full, stale);
        else n_pass++;
        mq.delete();
        exp_avg = 0;
        #10;
        @(negedge clock);
        resetn = 1'b1;
        void'(model_push(75));
        cycle(1'b1, 8'd75, 1'b0);
        n_total++; if (avg_out !== 8'd75 || fill_count !== 5'd1 || avg_valid !== 1'b1)
            $display("FAIL post_reset: got avg=%0d fill=%0d v=%0b expected 75 1 1", avg_out, fill_count, avg_valid);
        else n_pass++;
    endtask

    initial begin
        resetn       = 1'b0;
        sample_in    = 8'd0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        test_reset();
        test_fill();
        test_full_avg();
        test_clamp();
        test_clear_collision();
        test_back_to_back();
        test_stale();
        test_reset_mid_full();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
